// File: rtl/dat_mem_arbiter.sv
// Arbiter sharing single-port dat_mem between the core load/store path and a host/DMA port.
// Optional DAT_MEM_ARB_PERF_EN adds stall and host-grant performance counters.
//
// state | meaning
// IDLE  | no access this cycle
// SRV_C | core owns dat_mem this cycle (c_gnt=1)
// SRV_H | host owns dat_mem this cycle (h_gnt=1)
module dat_mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic [DW-1:0] c_rdata,
  output logic          c_rvalid,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic [DW-1:0] h_rdata,
  output logic          h_rvalid,
  input  logic          h_lock,
  output logic          stall,
`ifdef DAT_MEM_ARB_PERF_EN
  output logic [15:0]   c_stall_cnt,
  output logic [15:0]   h_gnt_cnt,
`endif
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SRV_C = 2'd1;
  localparam logic [1:0] SRV_H = 2'd2;

  localparam logic LAST_CORE = 1'b0;
  localparam logic LAST_HOST = 1'b1;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic          locked_q, locked_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] h_rdata_q, h_rdata_d;
  logic          c_rvalid_q, c_rvalid_d;
  logic          h_rvalid_q, h_rvalid_d;
  logic          elig_c, elig_h;

  assign c_gnt    = (state_q == SRV_C);
  assign h_gnt    = (state_q == SRV_H);
  assign c_rdata  = c_rdata_q;
  assign h_rdata  = h_rdata_q;
  assign c_rvalid = c_rvalid_q;
  assign h_rvalid = h_rvalid_q;
  assign stall    = c_req & ~c_gnt;

  always_comb begin
    // a request sampled at the edge that ends its own grant is consumed
    elig_c  = c_req & ~c_gnt & ~locked_q;
    elig_h  = h_req & ~h_gnt;
    state_d = IDLE;
    if (elig_c && elig_h) begin
      state_d = (last_q == LAST_HOST) ? SRV_C : SRV_H;
    end else if (elig_c) begin
      state_d = SRV_C;
    end else if (elig_h) begin
      state_d = SRV_H;
    end

    last_d = last_q;
    if (state_d == SRV_C) begin
      last_d = LAST_CORE;
    end else if (state_d == SRV_H) begin
      last_d = LAST_HOST;
    end

    locked_d = locked_q;
    if (!h_lock) begin
      locked_d = 1'b0;
    end else if (h_gnt) begin
      locked_d = 1'b1;
    end

    mem_addr  = '0;
    mem_din   = '0;
    mem_wr_en = 1'b0;
    case (state_q)
      SRV_C: begin
        mem_addr  = c_addr;
        mem_din   = c_wdata;
        mem_wr_en = c_we & ~reset;
      end
      SRV_H: begin
        mem_addr  = h_addr;
        mem_din   = h_wdata;
        mem_wr_en = h_we & ~reset;
      end
      default: ;
    endcase

    c_rvalid_d = c_gnt & ~c_we;
    h_rvalid_d = h_gnt & ~h_we;
    c_rdata_d  = c_rvalid_d ? mem_dout : c_rdata_q;
    h_rdata_d  = h_rvalid_d ? mem_dout : h_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= LAST_HOST;
      locked_q   <= 1'b0;
      c_rdata_q  <= '0;
      h_rdata_q  <= '0;
      c_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      locked_q   <= locked_d;
      c_rdata_q  <= c_rdata_d;
      h_rdata_q  <= h_rdata_d;
      c_rvalid_q <= c_rvalid_d;
      h_rvalid_q <= h_rvalid_d;
    end
  end

`ifdef DAT_MEM_ARB_PERF_EN
  logic [15:0] c_stall_cnt_q, c_stall_cnt_d;
  logic [15:0] h_gnt_cnt_q, h_gnt_cnt_d;

  assign c_stall_cnt = c_stall_cnt_q;
  assign h_gnt_cnt   = h_gnt_cnt_q;

  always_comb begin
    c_stall_cnt_d = c_stall_cnt_q;
    h_gnt_cnt_d   = h_gnt_cnt_q;
    if (stall && (c_stall_cnt_q != 16'hFFFF)) begin
      c_stall_cnt_d = c_stall_cnt_q + 16'd1;
    end
    if (h_gnt && (h_gnt_cnt_q != 16'hFFFF)) begin
      h_gnt_cnt_d = h_gnt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_stall_cnt_q <= '0;
      h_gnt_cnt_q   <= '0;
    end else begin
      c_stall_cnt_q <= c_stall_cnt_d;
      h_gnt_cnt_q   <= h_gnt_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_dat_mem_arbiter.sv
// Directed bench for dat_mem_arbiter with a behavioural dat_mem and a read-data scoreboard.
// Define DAT_MEM_ARB_PERF_EN for both files to include the counter checks.
module tb_dat_mem_arbiter;

  logic       clk;
  logic       reset;
  logic       c_req, c_we;
  logic [7:0] c_addr, c_wdata;
  logic       c_gnt, c_rvalid;
  logic [7:0] c_rdata;
  logic       h_req, h_we, h_lock;
  logic [7:0] h_addr, h_wdata;
  logic       h_gnt, h_rvalid;
  logic [7:0] h_rdata;
  logic       stall;
  logic       mem_wr_en;
  logic [7:0] mem_addr, mem_din, mem_dout;
`ifdef DAT_MEM_ARB_PERF_EN
  logic [15:0] c_stall_cnt, h_gnt_cnt;
`endif

  dat_mem_arbiter #(.AW(8), .DW(8)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .h_lock(h_lock), .stall(stall),
`ifdef DAT_MEM_ARB_PERF_EN
    .c_stall_cnt(c_stall_cnt), .h_gnt_cnt(h_gnt_cnt),
`endif
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // dat_mem: combinational read, synchronous write
  logic [7:0] mem [0:255];
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_din;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time=%0t, limit=200000)", $time);
    $fatal(1, "watchdog");
  end

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_mem [0:255];
  logic [7:0] qc [$];
  logic [7:0] qh [$];
  logic       pend_c = 1'b0;
  logic       pend_h = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // per-cycle scoreboard: read grants push expected data, rvalid pops it
  task automatic mon();
    logic [7:0] e;
    #1;
    if (pend_c) begin
      e = qc.pop_front();
      chk("c_rdata_sb", c_rdata, e);
    end
    chk("c_rvalid", c_rvalid, pend_c);
    if (pend_h) begin
      e = qh.pop_front();
      chk("h_rdata_sb", h_rdata, e);
    end
    chk("h_rvalid", h_rvalid, pend_h);
    pend_c = c_gnt && !c_we && !reset;
    pend_h = h_gnt && !h_we && !reset;
    if (pend_c) qc.push_back(exp_mem[c_addr]);
    if (pend_h) qh.push_back(exp_mem[h_addr]);
    if (c_gnt && c_we && !reset) exp_mem[c_addr] = c_wdata;
    if (h_gnt && h_we && !reset) exp_mem[h_addr] = h_wdata;
  endtask

  task automatic core_acc(input logic we, input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    tick();
    c_req = 1'b1; c_we = we; c_addr = a; c_wdata = d;
    mon();
    while (c_gnt !== 1'b1 && n < 8) begin
      tick(); mon(); n++;
    end
    chk("c_gnt_wait", c_gnt, 1'b1);
    chk("c_mem_addr", mem_addr, a);
    chk("c_mem_wr_en", mem_wr_en, we);
    if (we) chk("c_mem_din", mem_din, d);
    tick(); c_req = 1'b0; mon();
  endtask

  task automatic host_acc(input logic we, input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    tick();
    h_req = 1'b1; h_we = we; h_addr = a; h_wdata = d;
    mon();
    while (h_gnt !== 1'b1 && n < 8) begin
      tick(); mon(); n++;
    end
    chk("h_gnt_wait", h_gnt, 1'b1);
    chk("h_mem_addr", mem_addr, a);
    chk("h_mem_wr_en", mem_wr_en, we);
    if (we) chk("h_mem_din", mem_din, d);
    tick(); h_req = 1'b0; mon();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_c_gnt"}, c_gnt, 1'b0);
    chk({tag, "_h_gnt"}, h_gnt, 1'b0);
    chk({tag, "_c_rdata"}, c_rdata, 8'h00);
    chk({tag, "_h_rdata"}, h_rdata, 8'h00);
    chk({tag, "_mem_wr_en"}, mem_wr_en, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 8'h00);
    chk({tag, "_stall"}, stall, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
    reset = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0; h_lock = 0;

    // reset state
    tick(); tick(); tick(); mon();
    chk_reset_outputs("rst");
    tick(); reset = 1'b0; mon();
    chk_reset_outputs("rst_rel");

    // preload through the host port
    host_acc(1'b1, 8'h10, 8'h3C);
    host_acc(1'b1, 8'h20, 8'h5A);
    host_acc(1'b1, 8'h30, 8'h77);

    // core read only: grants 1,0,1,0 with stall in the gaps
    tick(); c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10; mon();
    chk("cro_gnt0", c_gnt, 1'b0); chk("cro_stall0", stall, 1'b1);
    tick(); mon();
    chk("cro_gnt1", c_gnt, 1'b1); chk("cro_stall1", stall, 1'b0);
    chk("cro_addr1", mem_addr, 8'h10);
    tick(); mon();
    chk("cro_gnt2", c_gnt, 1'b0); chk("cro_stall2", stall, 1'b1);
    chk("cro_rdata2", c_rdata, 8'h3C);
    tick(); mon();
    chk("cro_gnt3", c_gnt, 1'b1);
    tick(); c_req = 1'b0; mon();
    chk("cro_gnt4", c_gnt, 1'b0); chk("cro_rvalid4", c_rvalid, 1'b1);
    chk("cro_rdata4", c_rdata, 8'h3C);

    // host write then core read
    host_acc(1'b1, 8'h20, 8'h5A);
    core_acc(1'b0, 8'h20, 8'h00);
    chk("hw_cr_rdata", c_rdata, 8'h5A);

    // contention from reset release: C,H,C,H,... with no idle cycle
    tick(); reset = 1'b1; mon();
    tick(); reset = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
    h_req = 1'b1; h_we = 1'b0; h_addr = 8'h20;
    mon();
    chk("cont_c_gnt_idle", c_gnt, 1'b0); chk("cont_h_gnt_idle", h_gnt, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) begin c_req = 1'b0; h_req = 1'b0; end
      mon();
      chk("cont_c_gnt", c_gnt, (i % 2) == 0);
      chk("cont_h_gnt", h_gnt, (i % 2) == 1);
    end
    tick(); mon();
    chk("cont_h_rdata", h_rdata, 8'h5A);
    chk("cont_c_rdata", c_rdata, 8'h3C);

    // lock: host accesses every other cycle, core held off until after unlock
    tick(); h_req = 1'b1; h_we = 1'b0; h_addr = 8'h10; h_lock = 1'b1; mon();
    chk("lk0_h_gnt", h_gnt, 1'b0);
    tick(); mon();
    chk("lk1_h_gnt", h_gnt, 1'b1);
    tick(); c_req = 1'b1; c_we = 1'b0; c_addr = 8'h20; mon();
    chk("lk2_c_gnt", c_gnt, 1'b0); chk("lk2_stall", stall, 1'b1);
    tick(); mon();
    chk("lk3_h_gnt", h_gnt, 1'b1); chk("lk3_c_gnt", c_gnt, 1'b0);
    tick(); mon();
    chk("lk4_h_gnt", h_gnt, 1'b0); chk("lk4_c_gnt", c_gnt, 1'b0);
    tick(); h_lock = 1'b0; h_req = 1'b0; mon();
    chk("lk5_h_gnt", h_gnt, 1'b1); chk("lk5_c_gnt", c_gnt, 1'b0);
    tick(); mon();
    chk("lk6_c_gnt", c_gnt, 1'b0); chk("lk6_stall", stall, 1'b1);
    tick(); c_req = 1'b0; mon();
    chk("lk7_c_gnt", c_gnt, 1'b1); chk("lk7_addr", mem_addr, 8'h20);
    tick(); mon();
    chk("lk8_c_rdata", c_rdata, 8'h5A);
    chk("lk8_h_rdata", h_rdata, 8'h3C);

    // reset during a core write grant
    tick(); c_req = 1'b1; c_we = 1'b1; c_addr = 8'h30; c_wdata = 8'hEE; mon();
    chk("rma_c_gnt0", c_gnt, 1'b0);
    tick(); reset = 1'b1; mon();
    chk("rma_c_gnt1", c_gnt, 1'b1); chk("rma_wr_supp", mem_wr_en, 1'b0);
    tick(); reset = 1'b0; c_req = 1'b0; c_we = 1'b0; mon();
    chk_reset_outputs("rma");
    core_acc(1'b0, 8'h30, 8'h00);
    chk("rma_mem_kept", c_rdata, 8'h77);

`ifdef DAT_MEM_ARB_PERF_EN
    tick(); reset = 1'b1; mon();
    tick(); reset = 1'b0; mon();
    chk("perf_stall_clr", c_stall_cnt, 16'd0);
    chk("perf_hgnt_clr", h_gnt_cnt, 16'd0);
    for (int i = 0; i < 3; i++) host_acc(1'b0, 8'h10, 8'h00);
    for (int i = 0; i < 5; i++) core_acc(1'b0, 8'h20, 8'h00);
    tick(); mon();
    chk("perf_stall_cnt", c_stall_cnt, 16'd5);
    chk("perf_h_gnt_cnt", h_gnt_cnt, 16'd3);
`endif

    tick(); mon();
    chk("c_queue_drained", qc.size(), 0);
    chk("h_queue_drained", qh.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
